// File: rtl/uart_sys_ctrl.sv
// Command sequencer: parses framed bytes from the UART RX path and drives
// register-file writes/reads, ALU operations and the TX byte handshake.
module uart_sys_ctrl #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int FUN_W  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_W-1:0]     rx_data,
    input  logic                  rx_valid,
    output logic                  rf_wr_en,
    output logic                  rf_rd_en,
    output logic [ADDR_W-1:0]     rf_addr,
    output logic [DATA_W-1:0]     rf_wr_data,
    input  logic [DATA_W-1:0]     rf_rd_data,
    input  logic                  rf_rd_valid,
    output logic                  alu_en,
    output logic [FUN_W-1:0]      alu_fun,
    input  logic [2*DATA_W-1:0]   alu_out,
    input  logic                  alu_out_valid,
    output logic                  alu_clk_en,
    output logic [DATA_W-1:0]     tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  cmd_drop
);

    localparam logic [3:0] IDLE    = 4'd0;
    localparam logic [3:0] WR_ADDR = 4'd1;
    localparam logic [3:0] WR_DATA = 4'd2;
    localparam logic [3:0] RD_ADDR = 4'd3;
    localparam logic [3:0] RD_WAIT = 4'd4;
    localparam logic [3:0] ALU_A   = 4'd5;
    localparam logic [3:0] ALU_B   = 4'd6;
    localparam logic [3:0] ALU_FUN = 4'd7;
    localparam logic [3:0] ALU_RUN = 4'd8;
    localparam logic [3:0] TX_LO   = 4'd9;
    localparam logic [3:0] TX_HI   = 4'd10;

    localparam logic [DATA_W-1:0] CMD_RF_WR   = DATA_W'(8'hAA);
    localparam logic [DATA_W-1:0] CMD_RF_RD   = DATA_W'(8'hBB);
    localparam logic [DATA_W-1:0] CMD_ALU_OP  = DATA_W'(8'hCC);
    localparam logic [DATA_W-1:0] CMD_ALU_NOP = DATA_W'(8'hDD);

    logic [3:0]        state;
    logic [DATA_W-1:0] result_hi;
    logic              busy;

    // States that cannot accept a new byte; anything arriving here is dropped.
    assign busy = (state == RD_WAIT) || (state == ALU_RUN) ||
                  (state == TX_LO)   || (state == TX_HI);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            rf_wr_en   <= 1'b0;
            rf_rd_en   <= 1'b0;
            rf_addr    <= '0;
            rf_wr_data <= '0;
            alu_en     <= 1'b0;
            alu_fun    <= '0;
            alu_clk_en <= 1'b0;
            tx_data    <= '0;
            tx_valid   <= 1'b0;
            cmd_drop   <= 1'b0;
            result_hi  <= '0;
        end else begin
            // NOTE: strobes default low each cycle with non-blocking assignments,
            // so any branch that sets one produces exactly a one-cycle pulse.
            rf_wr_en <= 1'b0;
            rf_rd_en <= 1'b0;
            cmd_drop <= rx_valid && busy;

            case (state)
                IDLE: begin
                    if (rx_valid) begin
                        case (rx_data)
                            CMD_RF_WR: state <= WR_ADDR;
                            CMD_RF_RD: state <= RD_ADDR;
                            CMD_ALU_OP: begin
                                state      <= ALU_A;
                                alu_clk_en <= 1'b1;
                            end
                            CMD_ALU_NOP: begin
                                state      <= ALU_FUN;
                                alu_clk_en <= 1'b1;
                            end
                            default: cmd_drop <= 1'b1;
                        endcase
                    end
                end
                WR_ADDR: if (rx_valid) begin
                    rf_addr <= rx_data[ADDR_W-1:0];
                    state   <= WR_DATA;
                end
                WR_DATA: if (rx_valid) begin
                    rf_wr_data <= rx_data;
                    rf_wr_en   <= 1'b1;
                    state      <= IDLE;
                end
                RD_ADDR: if (rx_valid) begin
                    rf_addr  <= rx_data[ADDR_W-1:0];
                    rf_rd_en <= 1'b1;
                    state    <= RD_WAIT;
                end
                RD_WAIT: if (rf_rd_valid) begin
                    // A read returns a single byte, so it skips straight to TX_HI.
                    tx_data  <= rf_rd_data;
                    tx_valid <= 1'b1;
                    state    <= TX_HI;
                end
                ALU_A: if (rx_valid) begin
                    rf_addr    <= '0;
                    rf_wr_data <= rx_data;
                    rf_wr_en   <= 1'b1;
                    state      <= ALU_B;
                end
                ALU_B: if (rx_valid) begin
                    rf_addr    <= ADDR_W'(1);
                    rf_wr_data <= rx_data;
                    rf_wr_en   <= 1'b1;
                    state      <= ALU_FUN;
                end
                ALU_FUN: if (rx_valid) begin
                    alu_fun <= rx_data[FUN_W-1:0];
                    alu_en  <= 1'b1;
                    state   <= ALU_RUN;
                end
                ALU_RUN: if (alu_out_valid) begin
                    result_hi  <= alu_out[2*DATA_W-1:DATA_W];
                    tx_data    <= alu_out[DATA_W-1:0];
                    tx_valid   <= 1'b1;
                    alu_en     <= 1'b0;
                    alu_clk_en <= 1'b0;
                    state      <= TX_LO;
                end
                TX_LO: if (tx_ready) begin
                    tx_data <= result_hi;
                    state   <= TX_HI;
                end
                TX_HI: if (tx_ready) begin
                    tx_valid <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
